reset_sequencer: RTL and testbench

Parametrised reset and run-control sequencer that takes over the clock/reset bring-up that the simulation bench currently hard-codes. It accepts the raw asynchronous reset, synchronises its release, holds and then releases N reset channels in a staggered order, counts run cycles, and ends a run on a halt request or a watchdog timeout. It sits between the board/bench reset source and `riscv_top`'s internal reset domains. It is synthesisable and used in both FPGA and SIM builds.

---
 rtl/sim_pkg.sv | 30 +++
 rtl/reset_sequencer_if.sv | 42 ++++
 rtl/rst_sync.sv | 32 +++
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_pkg.sv
// Shared definitions for the reset/run-control sequencer.
// Holds the sequencer state enum, the run-counter width, the default
// parameter values and a helper that sizes the hold/stagger down-counter.
package sim_pkg;

   // Run-cycle counter width (cycle_cnt wraps at 2^CNT_W).
   localparam int unsigned CNT_W = 32;

   // Default parameter values for the sequencer and its synchroniser.
   localparam int unsigned DEF_CHANNELS    = 2;
   localparam int unsigned DEF_HOLD_CYCLES = 25;
   localparam int unsigned DEF_STAGGER     = 4;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_TIMEOUT     = 0;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_HOLD,
      ST_STAGGER,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } state_e;

   // Width of a down-counter that must hold values up to span-1; never zero.
   function automatic int unsigned seq_cnt_width(input int unsigned span);
      return (span > 1) ? $clog2(span) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Run-control bundle between the reset sequencer and its consumer.
//   sw_rst_req : consumer -> sequencer, single-cycle soft restart request
//   halt       : consumer -> sequencer, run-complete indication
//   rst_out    : sequencer -> consumer, per-channel active-high resets
//   ready      : sequencer -> consumer, all channels released and running
//   cycle_cnt  : sequencer -> consumer, run-cycle counter
//   done       : sequencer -> consumer, sticky, run ended on halt
//   timeout    : sequencer -> consumer, sticky, run ended on watchdog
// The master modport is the sequencer side, slave is the consumer side.
interface reset_sequencer_if
   import sim_pkg::*;
#(
   parameter int unsigned CHANNELS = DEF_CHANNELS
);
   logic                sw_rst_req;
   logic                halt;
   logic [CHANNELS-1:0] rst_out;
   logic                ready;
   logic [CNT_W-1:0]    cycle_cnt;
   logic                done;
   logic                timeout;

   modport master (
      input  sw_rst_req,
      input  halt,
      output rst_out,
      output ready,
      output cycle_cnt,
      output done,
      output timeout
   );

   modport slave (
      output sw_rst_req,
      output halt,
      input  rst_out,
      input  ready,
      input  cycle_cnt,
      input  done,
      input  timeout
   );
endinterface

// File: rtl/rst_sync.sv
// Reset-release synchroniser: asynchronous assert, synchronous deassert.
//   clk        : clock
//   rst        : raw asynchronous active-high reset
//   rst_sync_o : synchronised reset, goes low after edge SYNC_STAGES
module rst_sync
   import sim_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES  // must be >= 2
) (
   input  logic clk,
   input  logic rst,
   output logic rst_sync_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset and run-control sequencer.
// Synchronises release of the raw reset, holds all reset channels for
// HOLD_CYCLES, releases them one every STAGGER cycles in index order, then
// counts run cycles until a halt request or the watchdog ends the run.
//   clk : clock
//   rst : raw asynchronous active-high reset
//   bus : reset_sequencer_if.master (sw_rst_req/halt in; rst_out, ready,
//         cycle_cnt, done, timeout out; all outputs registered)
// HOLD_CYCLES is expected to be >= 2 so the power-on release lands exactly
// SYNC_STAGES+HOLD_CYCLES edges after reset drops.
module reset_sequencer
   import sim_pkg::*;
#(
   parameter int unsigned CHANNELS    = DEF_CHANNELS,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned STAGGER     = DEF_STAGGER,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   reset_sequencer_if.master bus
);

   localparam int unsigned CW = seq_cnt_width(HOLD_CYCLES + CHANNELS * STAGGER + 1);

   // The FSM only sees the synchroniser low one edge after it falls, and
   // leaves HOLD one edge after the counter reaches zero, so the power-on
   // load is two short of HOLD_CYCLES. A soft restart enters HOLD directly
   // on the request edge and therefore loads the full HOLD_CYCLES.
   localparam int unsigned PO_HOLD  = (HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0;
   localparam int unsigned STG_HOLD = (STAGGER > 0) ? STAGGER - 1 : 0;

   localparam logic [CW-1:0] PO_LOAD  = CW'(PO_HOLD);
   localparam logic [CW-1:0] SW_LOAD  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] STG_LOAD = CW'(STG_HOLD);

   state_e              state_q,     state_d;
   logic [CW-1:0]       cnt_q,       cnt_d;
   logic [CHANNELS-1:0] rst_out_q,   rst_out_d;
   logic                ready_q,     ready_d;
   logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
   logic                done_q,      done_d;
   logic                timeout_q,   timeout_d;

   logic                sync_rst;
   logic [CHANNELS-1:0] release_mask;
   logic                sw_restart;
   logic                wdog_hit;
   logic                cnt_zero;

   rst_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rst_sync (
      .clk       (clk),
      .rst       (rst),
      .rst_sync_o(sync_rst)
   );

   always_comb begin
      // Channels still in reset are the set bits; releasing the next one in
      // index order clears the lowest set bit. STAGGER=0 releases them all.
      if (STAGGER == 0) begin
         release_mask = '0;
      end else begin
         release_mask = rst_out_q & (rst_out_q - CHANNELS'(1));
      end
      sw_restart = bus.sw_rst_req && (state_q != ST_SYNC);
      wdog_hit   = (TIMEOUT != 0) && (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
      cnt_zero   = (cnt_q == '0);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SYNC;
         cnt_q       <= '0;
         rst_out_q   <= '1;
         ready_q     <= 1'b0;
         cycle_cnt_q <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rst_out_q   <= rst_out_d;
         ready_q     <= ready_d;
         cycle_cnt_q <= cycle_cnt_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state and hold/stagger counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_SYNC: begin
            if (!sync_rst) begin
               state_d = ST_HOLD;
               cnt_d   = PO_LOAD;
            end
         end
         ST_HOLD, ST_STAGGER: begin
            if (cnt_zero) begin
               state_d = (release_mask == '0) ? ST_RUN : ST_STAGGER;
               cnt_d   = STG_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RUN: begin
            if (bus.halt) begin
               state_d = ST_DONE;
            end else if (wdog_hit) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: begin
         end
      endcase
      if (sw_restart) begin
         state_d = ST_HOLD;
         cnt_d   = SW_LOAD;
      end
   end

   // Output next values
   always_comb begin
      rst_out_d   = rst_out_q;
      ready_d     = ready_q;
      cycle_cnt_d = cycle_cnt_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      unique case (state_q)
         ST_HOLD, ST_STAGGER: begin
            if (cnt_zero) begin
               rst_out_d = release_mask;
               ready_d   = (release_mask == '0);
            end
         end
         ST_RUN: begin
            if (bus.halt) begin
               done_d  = 1'b1;
               ready_d = 1'b0;
            end else if (wdog_hit) begin
               timeout_d = 1'b1;
               rst_out_d = '1;
               ready_d   = 1'b0;
            end else begin
               cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase
      if (sw_restart) begin
         rst_out_d   = '1;
         ready_d     = 1'b0;
         cycle_cnt_d = '0;
         done_d      = 1'b0;
         timeout_d   = 1'b0;
      end
   end

   assign bus.rst_out   = rst_out_q;
   assign bus.ready     = ready_q;
   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.done      = done_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two instances share clk/rst and the
// same sw_rst_req/halt stimulus. A: CHANNELS=2, STAGGER=4, TIMEOUT=1000.
// B: CHANNELS=4, STAGGER=0, TIMEOUT=0. Expected outputs come from an
// event-time model (release edges, run start edge, end-of-run event).
module tb_reset_sequencer;
   import sim_pkg::*;

   localparam int H = 25;
   localparam int S = 2;

   typedef struct packed {
      logic [3:0]  rst_out;
      logic        ready;
      logic [31:0] cnt;
      logic        done;
      logic        to;
      int          edge_no;
   } snap_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   reset_sequencer_if #(.CHANNELS(2)) bus_a ();
   reset_sequencer_if #(.CHANNELS(4)) bus_b ();

   reset_sequencer #(
      .CHANNELS(2), .HOLD_CYCLES(25), .STAGGER(4), .SYNC_STAGES(2), .TIMEOUT(1000)
   ) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   reset_sequencer #(
      .CHANNELS(4), .HOLD_CYCLES(25), .STAGGER(0), .SYNC_STAGES(2), .TIMEOUT(0)
   ) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   snap_t qa[$];
   snap_t qb[$];

   // Model state per instance: edge where channel 0 releases, edge where the
   // run starts (last release), end-of-run kind (0 none, 1 halt, 2 watchdog)
   // and the frozen count after a halt.
   int edge_n;
   int rel_base[2];
   int run_start[2];
   int end_kind[2];
   int frozen[2];

   function automatic int ch(input int d);
      return (d == 0) ? 2 : 4;
   endfunction
   function automatic int stg(input int d);
      return (d == 0) ? 4 : 0;
   endfunction
   function automatic int tmo(input int d);
      return (d == 0) ? 1000 : 0;
   endfunction

   function automatic void model_power_on();
      edge_n = 0;
      for (int d = 0; d < 2; d++) begin
         rel_base[d]  = S + H;
         run_start[d] = rel_base[d] + (ch(d) - 1) * stg(d);
         end_kind[d]  = 0;
         frozen[d]    = 0;
      end
   endfunction

   function automatic void model_edge(input int d, input int k, input logic sw, input logic h);
      if (sw) begin
         rel_base[d]  = k + 1 + H;
         run_start[d] = rel_base[d] + (ch(d) - 1) * stg(d);
         end_kind[d]  = 0;
      end else if (end_kind[d] == 0 && k > run_start[d]) begin
         if (h) begin
            end_kind[d] = 1;
            frozen[d]   = k - 1 - run_start[d];
         end else if (tmo(d) != 0 && (k - 1 - run_start[d]) == tmo(d) - 1) begin
            end_kind[d] = 2;
         end
      end
   endfunction

   function automatic snap_t reset_snap(input int d);
      snap_t s;
      s = '0;
      for (int i = 0; i < ch(d); i++) s.rst_out[i] = 1'b1;
      s.edge_no = -1;
      return s;
   endfunction

   function automatic snap_t model_out(input int d, input int k);
      snap_t s;
      s = '0;
      s.edge_no = k;
      if (end_kind[d] == 0) begin
         for (int i = 0; i < ch(d); i++) s.rst_out[i] = (k < rel_base[d] + i * stg(d));
         s.ready = (k >= run_start[d]);
         s.cnt   = s.ready ? 32'(k - run_start[d]) : 32'd0;
      end else if (end_kind[d] == 1) begin
         s.done = 1'b1;
         s.cnt  = 32'(frozen[d]);
      end else begin
         for (int i = 0; i < ch(d); i++) s.rst_out[i] = 1'b1;
         s.cnt = 32'(tmo(d) - 1);
         s.to  = 1'b1;
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int e);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, e, act, exp);
      end
   endtask

   // Drive inputs for the next edge, advance the model, queue the expectation.
   task automatic step(input logic sw, input logic h);
      bus_a.sw_rst_req = sw;
      bus_a.halt       = h;
      bus_b.sw_rst_req = sw;
      bus_b.halt       = h;
      edge_n++;
      for (int d = 0; d < 2; d++) model_edge(d, edge_n, sw, h);
      qa.push_back(model_out(0, edge_n));
      qb.push_back(model_out(1, edge_n));
      @(negedge clk);
   endtask

   task automatic do_rst(input int ncyc);
      bus_a.sw_rst_req = 1'b0;
      bus_a.halt       = 1'b0;
      bus_b.sw_rst_req = 1'b0;
      bus_b.halt       = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_out_a", {30'd0, bus_a.rst_out}, 32'h3, -1);
      chk("async_rst_out_b", {28'd0, bus_b.rst_out}, 32'hf, -1);
      chk("async_ready_a", {31'd0, bus_a.ready}, 32'd0, -1);
      for (int n = 0; n < ncyc; n++) begin
         qa.push_back(reset_snap(0));
         qb.push_back(reset_snap(1));
         @(negedge clk);
      end
      rst = 1'b0;
      model_power_on();
   endtask

   // Advance with idle inputs until instance A's run count (as sampled at the
   // coming edge) reaches target; an expired bound counts as a failure.
   task automatic wait_cnt_a(input int target, input string name);
      int n;
      n = 0;
      while (!(end_kind[0] == 0 && edge_n - run_start[0] == target) && n < 5000) begin
         step(1'b0, 1'b0);
         n++;
      end
      n_checks++;
      if (n >= 5000) begin
         n_fail++;
         $display("FAIL %s: run count %0d not reached within bound", name, target);
      end
   endtask

   // Monitor: compare every presented output against the queued expectation.
   initial begin
      snap_t ea;
      snap_t eb;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk("a_rst_out",   {30'd0, bus_a.rst_out}, {28'd0, ea.rst_out}, ea.edge_no);
            chk("a_ready",     {31'd0, bus_a.ready},   {31'd0, ea.ready},   ea.edge_no);
            chk("a_cycle_cnt", bus_a.cycle_cnt,        ea.cnt,              ea.edge_no);
            chk("a_done",      {31'd0, bus_a.done},    {31'd0, ea.done},    ea.edge_no);
            chk("a_timeout",   {31'd0, bus_a.timeout}, {31'd0, ea.to},      ea.edge_no);
            chk("b_rst_out",   {28'd0, bus_b.rst_out}, {28'd0, eb.rst_out}, eb.edge_no);
            chk("b_ready",     {31'd0, bus_b.ready},   {31'd0, eb.ready},   eb.edge_no);
            chk("b_cycle_cnt", bus_b.cycle_cnt,        eb.cnt,              eb.edge_no);
            chk("b_done",      {31'd0, bus_b.done},    {31'd0, eb.done},    eb.edge_no);
            chk("b_timeout",   {31'd0, bus_b.timeout}, {31'd0, eb.to},      eb.edge_no);
         end
      end
   end

   initial begin
      int n;
      logic sw;
      logic h;
      bus_a.sw_rst_req = 1'b0;
      bus_a.halt       = 1'b0;
      bus_b.sw_rst_req = 1'b0;
      bus_b.halt       = 1'b0;
      model_power_on();
      #2;

      // Power-on, then halt at A count 100
      do_rst(10);
      wait_cnt_a(100, "halt_wait");
      step(1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0);

      // Soft restart out of DONE, then let A's watchdog expire
      step(1'b1, 1'b0);
      n = 0;
      while (end_kind[0] != 2 && n < 2000) begin
         step(1'b0, 1'b0);
         n++;
      end
      repeat (20) step(1'b0, 1'b0);

      // Soft restart out of TIMEOUT, then soft restart at A count 50
      step(1'b1, 1'b0);
      wait_cnt_a(50, "sw_wait");
      step(1'b1, 1'b0);

      // Halt and soft restart on the same edge
      wait_cnt_a(20, "same_edge_wait");
      step(1'b1, 1'b1);

      // Async reset between A's two channel releases, then full power-on
      n = 0;
      while (edge_n != rel_base[0] + 1 && n < 200) begin
         step(1'b0, 1'b0);
         n++;
      end
      do_rst(3);
      wait_cnt_a(20, "repower_wait");

      // Randomised halt / soft-restart traffic
      for (int i = 0; i < 2000; i++) begin
         sw = (edge_n >= 6) && ($urandom_range(0, 149) == 0);
         h  = ($urandom_range(0, 59) == 0);
         step(sw, h);
      end
      repeat (5) step(1'b0, 1'b0);

      n = 0;
      while (qa.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (qa.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", qa.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
